reduce_vector_alu_lanes: RTL and testbench

Multi-lane successor to the single-element reduce unit. It captures a vector of N signed elements plus a length, then reduces LANES elements per clock. All eight reductions are computed concurrently: sum, or, and, xor, min, max, argmin and argmax. It sits behind the vector register file as the scalar-result engine, with a start/busy/done handshake and a tri-state result bus shared with the other ALUs.

---
 rtl/reduce_vector_alu_lanes.sv | 172 +++++++++++++++++
 tb/tb_reduce_vector_alu_lanes.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reduce_vector_alu_lanes.sv
// Multi-lane vector reduction unit: sum/or/and/xor/min/max/argmin/argmax over
// a captured vector, LANES elements per clock, with a tri-state result bus.

module reduce_lane #(
  parameter int BITS = 8,
  parameter int IW   = 7,
  parameter int SW   = 15,
  parameter int K    = 0
) (
  input  logic [IW-1:0]   base,
  input  logic [IW-1:0]   len,
  input  logic [BITS-1:0] elem,
  output logic            live,
  output logic [BITS-1:0] pos,
  output logic [SW-1:0]   sum_c,
  output logic [BITS-1:0] or_c,
  output logic [BITS-1:0] and_c,
  output logic [BITS-1:0] xor_c
);
  logic [IW-1:0] idx;

  assign idx   = base + IW'(K);
  assign live  = idx < len;
  assign pos   = BITS'(idx);
  // Masked lanes present the identity of each operator.
  assign sum_c = live ? {{(SW-BITS){elem[BITS-1]}}, elem} : '0;
  assign or_c  = live ? elem : '0;
  assign and_c = live ? elem : '1;
  assign xor_c = live ? elem : '0;
endmodule

module reduce_vector_alu_lanes #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int LANES = 4,
  parameter int SAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0][BITS-1:0] in,
  input  logic [BITS-1:0]      in_len,
  input  logic [2:0]           op,
  input  logic                 start,
  input  logic                 en,
  output tri logic [BITS-1:0]  out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int IW = $clog2(N) + 1;
  localparam int SW = BITS + $clog2(N) + 1;
  localparam logic [BITS-1:0] EMAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] EMIN = ~EMAX;
  localparam logic [SW-1:0]   SMAX = {{(SW-BITS){1'b0}}, EMAX};
  localparam logic [SW-1:0]   SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_n;

  logic [N-1:0][BITS-1:0] vec_q;
  logic [IW-1:0]   len_q, idx_q;
  logic [SW-1:0]   sum_q, sum_n;
  logic [BITS-1:0] or_q, and_q, xor_q, min_q, max_q, amin_q, amax_q;
  logic [BITS-1:0] or_n, and_n, xor_n, min_n, max_n, amin_n, amax_n;
  logic            err_q;

  logic [LANES-1:0]           live;
  logic [LANES-1:0][BITS-1:0] pos, or_c, and_c, xor_c;
  logic [LANES-1:0][SW-1:0]   sum_c;

  // The vector shifts down by one chunk per RUN cycle, so lane k always reads slot k.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    reduce_lane #(.BITS(BITS), .IW(IW), .SW(SW), .K(k)) u_lane (
      .base(idx_q), .len(len_q), .elem(vec_q[k]), .live(live[k]), .pos(pos[k]),
      .sum_c(sum_c[k]), .or_c(or_c[k]), .and_c(and_c[k]), .xor_c(xor_c[k])
    );
  end

  logic cap, last;
  assign cap  = start && (state_q != RUN);
  assign last = (idx_q + IW'(LANES)) >= len_q;

  // Lanes folded in ascending index with strict compares keeps the lowest index on ties.
  always_comb begin
    sum_n = sum_q; or_n = or_q; and_n = and_q; xor_n = xor_q;
    min_n = min_q; max_n = max_q; amin_n = amin_q; amax_n = amax_q;
    for (int k = 0; k < LANES; k++) begin
      sum_n = sum_n + sum_c[k];
      or_n  = or_n | or_c[k];
      and_n = and_n & and_c[k];
      xor_n = xor_n ^ xor_c[k];
      if (live[k] && ($signed(vec_q[k]) < $signed(min_n))) begin
        min_n  = vec_q[k];
        amin_n = pos[k];
      end
      if (live[k] && ($signed(vec_q[k]) > $signed(max_n))) begin
        max_n  = vec_q[k];
        amax_n = pos[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0; len_q <= '0; idx_q <= '0; err_q <= 1'b0;
      sum_q <= '0; or_q <= '0; and_q <= '1; xor_q <= '0;
      min_q <= EMAX; max_q <= EMIN; amin_q <= '0; amax_q <= '0;
    end else if (cap) begin
      vec_q <= in;
      idx_q <= '0;
      if (32'(in_len) > 32'(N)) begin
        len_q <= IW'(N);
        err_q <= 1'b1;
      end else begin
        len_q <= IW'(in_len);
        err_q <= 1'b0;
      end
      sum_q <= '0; or_q <= '0; and_q <= '1; xor_q <= '0;
      min_q <= EMAX; max_q <= EMIN; amin_q <= '0; amax_q <= '0;
    end else if (state_q == RUN) begin
      vec_q <= vec_q >> (LANES*BITS);
      idx_q <= idx_q + IW'(LANES);
      sum_q <= sum_n; or_q <= or_n; and_q <= and_n; xor_q <= xor_n;
      min_q <= min_n; max_q <= max_n; amin_q <= amin_n; amax_q <= amax_n;
    end
  end

  logic [BITS-1:0] sum_res, res;

  always_comb begin
    sum_res = sum_q[BITS-1:0];
    if (SAT != 0) begin
      if ($signed(sum_q) > $signed(SMAX))      sum_res = EMAX;
      else if ($signed(sum_q) < $signed(SMIN)) sum_res = EMIN;
    end
  end

  always_comb begin
    res = '0;
    case (op)
      3'b000: res = sum_res;
      3'b001: res = or_q;
      3'b010: res = min_q;
      3'b011: res = max_q;
      3'b100: res = and_q;
      3'b101: res = xor_q;
      3'b110: res = amin_q;
      3'b111: res = amax_q;
      default: res = '0;
    endcase
  end

  assign out  = en ? res : 'z;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign err  = err_q;
endmodule

// File: tb/tb_reduce_vector_alu_lanes.sv
// Scoreboard bench: stimulus pushes model results at each start edge; a monitor
// sweeps op on every done rise and compares both wrap and saturating instances.
`timescale 1ns/1ps
module tb_reduce_vector_alu_lanes;
  localparam int BITS = 8, N = 64, LANES = 4;

  logic clk = 1'b0;
  logic rst, start, en;
  logic [N-1:0][BITS-1:0] in_v;
  logic [BITS-1:0] in_len;
  logic [2:0] op;
  wire  [BITS-1:0] out, out_s;
  logic busy, done, err, busy_s, done_s, err_s;

  always #20 clk = ~clk;

  reduce_vector_alu_lanes #(.BITS(BITS), .N(N), .LANES(LANES), .SAT(0)) dut (
    .clk(clk), .rst(rst), .in(in_v), .in_len(in_len), .op(op), .start(start),
    .en(en), .out(out), .busy(busy), .done(done), .err(err));
  reduce_vector_alu_lanes #(.BITS(BITS), .N(N), .LANES(LANES), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .in(in_v), .in_len(in_len), .op(op), .start(start),
    .en(en), .out(out_s), .busy(busy_s), .done(done_s), .err(err_s));

  typedef struct {
    logic [7:0][BITS-1:0] r;
    logic [BITS-1:0]      sat_sum;
    logic                 err;
    int                   lat;
    int                   scyc;
  } exp_t;

  exp_t expq[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, issued = 0, checked = 0, busy_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer walk over the valid prefix of the vector.
  function automatic exp_t model(input logic [N-1:0][BITS-1:0] v, input int ilen);
    exp_t e;
    int len, s, mn, mx, amn, amx, val, hi, lo;
    logic [BITS-1:0] o, a, x;
    hi = 2**(BITS-1) - 1; lo = -(2**(BITS-1));
    len = (ilen > N) ? N : ilen;
    e.err = (ilen > N);
    s = 0; o = '0; a = '1; x = '0; mn = hi; mx = lo; amn = 0; amx = 0;
    for (int i = 0; i < len; i++) begin
      val = $signed(v[i]);
      s += val; o |= v[i]; a &= v[i]; x ^= v[i];
      if (val < mn) begin mn = val; amn = i; end
      if (val > mx) begin mx = val; amx = i; end
    end
    e.r[0] = s[BITS-1:0]; e.r[1] = o; e.r[2] = mn[BITS-1:0]; e.r[3] = mx[BITS-1:0];
    e.r[4] = a; e.r[5] = x; e.r[6] = amn[BITS-1:0]; e.r[7] = amx[BITS-1:0];
    val = (s > hi) ? hi : ((s < lo) ? lo : s);
    e.sat_sum = val[BITS-1:0];
    e.lat = (len == 0) ? 1 : (len + LANES - 1) / LANES;
    e.scyc = 0;
    return e;
  endfunction

  task automatic launch(input logic [N-1:0][BITS-1:0] v, input int len, input bit push);
    exp_t e;
    @(posedge clk); #1;
    in_v = v; in_len = len[BITS-1:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e = model(v, len);
      e.scyc = cyc;
      expq.push_back(e);
      issued++;
    end
  endtask

  task automatic wait_checked();
    int t = 0;
    while (checked < issued && t < 400) begin @(posedge clk); t++; end
    if (checked < issued) begin
      chk("done_timeout", 32'(checked), 32'(issued));
      checked = issued;
      expq.delete();
    end
  endtask

  task automatic reset_check(input string tag);
    logic [7:0][BITS-1:0] rv;
    rv = {8'h00, 8'h00, 8'h00, 8'hff, 8'h80, 8'h7f, 8'h00, 8'h00};
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    for (int o = 0; o < 8; o++) begin
      op = o[2:0]; #1;
      chk($sformatf("%s_op%0d", tag, o), out, rv[o]);
    end
    op = 3'd0;
  endtask

  initial begin : monitor
    bit pd = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin pd = 0; busy_cnt = 0; continue; end
      if (busy) busy_cnt++;
      if (done && !pd) begin
        if (expq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = expq.pop_front();
          chk("latency", 32'(cyc - e.scyc), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
          chk("busy_low", busy, 0);
          chk("err", err, e.err);
          chk("sat_inst_flags", {done_s, busy_s, err_s}, {1'b1, 1'b0, e.err});
          for (int o = 0; o < 8; o++) begin
            op = o[2:0]; #1;
            chk($sformatf("op%0d", o), out, e.r[o]);
          end
          op = 3'd0; #1;
          chk("sat_sum", out_s, e.sat_sum);
          en = 1'b0; #1;
          vectors++;
          if (out !== 'z) begin
            miscompares++;
            $display("FAIL en_off: got %0h expected z", out);
          end
          en = 1'b1;
        end
        checked++;
        busy_cnt = 0;
      end
      pd = done;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [N-1:0][BITS-1:0] v, v2;
    rst = 1'b1; start = 1'b0; en = 1'b1; op = 3'd0; in_len = '0; in_v = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_check("reset");

    for (int i = 0; i < N; i++) v[i] = BITS'(i + 1);
    launch(v, 10, 1); wait_checked();

    v = '0;
    v[0] = 8'd5; v[1] = 8'hfd; v[2] = 8'd7; v[3] = 8'hfd; v[4] = 8'd7;
    launch(v, 5, 1); wait_checked();

    for (int i = 0; i < N; i++) v[i] = 8'd100;
    launch(v, 64, 1); wait_checked();

    launch(v, 0, 1); wait_checked();

    for (int i = 0; i < N; i++) v[i] = 8'd1;
    launch(v, 70, 1); wait_checked();
    launch(v, 4, 1); wait_checked();

    // Start pulsed mid-run must neither recapture nor restart.
    for (int i = 0; i < N; i++) v[i] = BITS'($urandom);
    for (int i = 0; i < N; i++) v2[i] = BITS'($urandom);
    launch(v, 64, 1);
    repeat (2) @(posedge clk);
    launch(v2, 8, 0);
    wait_checked();

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        v[i] = (it % 2 == 0) ? BITS'($urandom_range(0, 7) - 4) : BITS'($urandom);
      if (it % 5 == 0) v[$urandom_range(0, N-1)] = 8'h80;
      launch(v, int'($urandom_range(0, 80)), 1);
      wait_checked();
    end

    // Asynchronous reset two cycles into a full-length run.
    launch(v, 64, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    reset_check("midrun_rst");
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", done, 0);

    launch(v, 9, 1); wait_checked();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
